// File: rtl/rate_limiter.sv
`default_nettype none
// ============================================================================
// Module      : rate_limiter
// Description : Two-stage slow strobe generator (fixed prescaler feeding a
//               programmable 8-bit divider) for animation update timing.
// Revision    : 1.0 - initial release
// ============================================================================
module rate_limiter #(
    parameter int PRESCALE = 833333,
    parameter int PW       = 20
) (
    output logic       slow_clock,
    input  logic       clock,
    input  logic [7:0] rate,
    input  logic       reset
);

    localparam logic [PW-1:0] c_pre_last = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] c_pre_one  = PW'(1);
    localparam logic [7:0]    c_one      = 8'd1;

    logic [PW-1:0] r_pre_cnt;
    logic [7:0]    r_tick_cnt;
    logic [7:0]    r_rate_q;
    logic          r_strobe;
    logic          w_base_tick;
    logic          w_period_end;

    assign w_base_tick  = (r_pre_cnt == c_pre_last);
    assign w_period_end = (r_tick_cnt == (r_rate_q - c_one));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre_cnt  <= '0;
            r_tick_cnt <= '0;
            r_rate_q   <= rate;
            r_strobe   <= 1'b0;
        end else begin
            r_strobe  <= 1'b0;
            r_pre_cnt <= w_base_tick ? '0 : r_pre_cnt + c_pre_one;
            if (w_base_tick) begin
                // A zero rate parks the divider but keeps polling for a new rate.
                if (r_rate_q == 8'd0) begin
                    r_tick_cnt <= '0;
                    r_rate_q   <= rate;
                end else if (w_period_end) begin
                    r_tick_cnt <= '0;
                    r_strobe   <= 1'b1;
                    r_rate_q   <= rate;
                end else begin
                    r_tick_cnt <= r_tick_cnt + c_one;
                end
            end
        end
    end

    assign slow_clock = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_rate_limiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rate_limiter
// Description : Scoreboard bench for rate_limiter at PRESCALE 4, 1 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rate_limiter;

    logic       clock;
    logic       reset;
    logic [7:0] rate;
    logic       sc_p4;
    logic       sc_p1;
    logic       sc_p2;

    int    sel;
    int    cyc;
    int    n_checks;
    int    n_pass;
    string cur_test;
    bit    exp_q[$];

    rate_limiter #(.PRESCALE(4), .PW(3)) u_dut_p4 (
        .slow_clock (sc_p4),
        .clock      (clock),
        .rate       (rate),
        .reset      (reset)
    );

    rate_limiter #(.PRESCALE(1), .PW(1)) u_dut_p1 (
        .slow_clock (sc_p1),
        .clock      (clock),
        .rate       (rate),
        .reset      (reset)
    );

    rate_limiter #(.PRESCALE(2), .PW(2)) u_dut_p2 (
        .slow_clock (sc_p2),
        .clock      (clock),
        .rate       (rate),
        .reset      (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic obs();
        case (sel)
            0:       return sc_p4;
            1:       return sc_p1;
            default: return sc_p2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s/%s cyc=%0d got=%0d exp=%0d", cur_test, tag, cyc, got, exp);
        else
            n_pass++;
    endtask

    // Expected value for the cycle after the next posedge is queued, then
    // popped and compared once the DUT has produced it.
    task automatic tick(input bit exp_hi);
        exp_q.push_back(exp_hi);
        @(posedge clock);
        cyc++;
        @(negedge clock);
        check("strobe", {31'd0, obs()}, {31'd0, exp_q.pop_front()});
    endtask

    task automatic do_reset(input logic [7:0] r, input int n);
        reset = 1'b1;
        rate  = r;
        repeat (n) tick(1'b0);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        sel      = 0;
        reset    = 1'b1;
        rate     = 8'd3;

        // Period 12 at PRESCALE=4, rate=3
        cur_test = "basic";
        sel = 0;
        do_reset(8'd3, 2);
        repeat (40) tick(((cyc + 1) % 12) == 0);

        // PRESCALE=1: rate 1 strobes every cycle, switching to 2 alternates
        cur_test = "p1";
        sel = 1;
        do_reset(8'd1, 2);
        repeat (6) tick(1'b1);
        rate = 8'd2;
        repeat (10) tick(((cyc + 1) <= 7) || (((cyc + 1) % 2) == 1));

        // Mid-period rate change does not truncate the current period
        cur_test = "ratechg";
        sel = 0;
        do_reset(8'd3, 2);
        repeat (6) tick(1'b0);
        rate = 8'd5;
        repeat (49) tick(((cyc + 1) == 12) || ((cyc + 1) == 32) || ((cyc + 1) == 52));

        // rate 0 parks the divider; new rate picked up at next base tick (104)
        cur_test = "rate0";
        sel = 0;
        do_reset(8'd0, 2);
        repeat (100) tick(1'b0);
        rate = 8'd2;
        repeat (22) tick(((cyc + 1) == 112) || ((cyc + 1) == 120));

        // Reset spanning the edge that would have fired the pulse
        cur_test = "midreset";
        sel = 0;
        do_reset(8'd3, 2);
        repeat (10) tick(1'b0);
        do_reset(8'd3, 2);
        repeat (26) tick(((cyc + 1) % 12) == 0);

        // Reset during an active pulse drops it on the next cycle
        cur_test = "pulsereset";
        sel = 0;
        do_reset(8'd3, 2);
        repeat (12) tick(((cyc + 1) % 12) == 0);
        do_reset(8'd3, 1);
        repeat (13) tick(((cyc + 1) % 12) == 0);

        // Maximum rate at PRESCALE=2: 510-cycle period
        cur_test = "rate255";
        sel = 2;
        do_reset(8'd255, 2);
        repeat (1535) tick(((cyc + 1) % 510) == 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
